// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_DONE = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter; the output only follows
// the synchronised input after FILTER_LEN consecutive differing samples.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_di,
  output logic line_q
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], line_di};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (32'(cnt_q) + 32'd1 >= FILTER_LEN) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_q = filt_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, pointer-based register
// writes and reads mapped onto a byte strobe port. Open-drain SDA only.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR   = 7'h42,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_di,
  input  logic              sda_di,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_strobe,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data
);

  logic scl_f, sda_f;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .reset   (reset),
    .line_di (scl_di),
    .line_q  (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .reset   (reset),
    .line_di (sda_di),
    .line_q  (sda_f)
  );

  i2c_state_e        state_q, state_d;
  logic              scl_prev_q, scl_prev_d;
  logic              sda_prev_q, sda_prev_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_load_q, rd_load_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte;
  logic       last_bit, addr_hit;

  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start_ev = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_ev  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign rx_byte  = {shift_q[6:0], sda_f};
  assign last_bit = (cnt_q == BIT_LAST);
  assign addr_hit = (rx_byte[7:1] == I2C_ADDR);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = ST_IDLE;
    end else if (start_ev) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && last_bit) state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        end
        // The ACK drive itself (sda_oe_q) marks that the ACK bit is on the bus.
        ST_ADDR_ACK: begin
          if (scl_rise && sda_oe_q) state_d = (rw_q == I2C_RW_WRITE) ? ST_PTR : ST_RDATA;
        end
        ST_PTR: begin
          if (scl_rise && last_bit) state_d = ST_PTR_ACK;
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise && sda_oe_q) state_d = ST_WDATA;
        end
        ST_WDATA: begin
          if (scl_rise && last_bit) state_d = ST_WDATA_ACK;
        end
        ST_RDATA: begin
          if (scl_fall && cnt_q == BIT_DONE) state_d = ST_RDATA_ACK;
        end
        ST_RDATA_ACK: begin
          if (scl_rise) state_d = sda_f ? ST_WAIT_STOP : ST_RDATA;
        end
        default: ;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    scl_prev_d  = scl_f;
    sda_prev_d  = sda_f;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_load_d   = rd_strobe_q;

    if (stop_ev || start_ev) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (last_bit) begin
              cnt_d = '0;
              rw_d  = sda_f;
              if (addr_hit) busy_d = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise && sda_oe_q) begin
            cnt_d = '0;
            if (rw_q == I2C_RW_READ) begin
              rd_strobe_d = 1'b1;
              rd_addr_d   = ptr_q;
            end
          end
        end
        ST_PTR: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (last_bit) begin
              cnt_d = '0;
              ptr_d = ADDR_W'(rx_byte);
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall && !sda_oe_q) sda_oe_d = 1'b1;
        end
        ST_WDATA: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (last_bit) begin
              cnt_d       = '0;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + 1'b1;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == BIT_DONE) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              cnt_d    = '0;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && !sda_f) begin
            rd_strobe_d = 1'b1;
            rd_addr_d   = ptr_q;
            cnt_d       = '0;
          end
        end
        default: ;
      endcase
    end

    // Host returns rd_data one clock after rd_strobe
    if (rd_load_q) shift_d = rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_load_q   <= 1'b0;
    end else begin
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      rd_addr_q   <= rd_addr_d;
      rd_load_q   <= rd_load_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_strobe = rd_strobe_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, register-file host, and a
// pointer/memory reference model of the protocol.
module tb_i2c_target;

  localparam int unsigned Q = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_c = 1'b1, sda_c = 1'b1, scl_glitch = 1'b0;
  logic scl_di, sda_di, sda_oe, busy, wr_strobe, rd_strobe;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  assign scl_di = scl_c & ~scl_glitch;
  assign sda_di = sda_c & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.I2C_ADDR(7'h42), .ADDR_W(8), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_di    (scl_di),
    .sda_di    (sda_di),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_strobe (rd_strobe),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  logic [7:0] host_mem [256];
  always @(posedge clk) begin
    if (rd_strobe) rd_data <= host_mem[rd_addr];
    if (wr_strobe) host_mem[wr_addr] <= wr_data;
  end

  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int oe_cycles = 0, busy_cycles = 0, both_cycles = 0;
  always @(negedge clk) begin
    if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
    if (rd_strobe) rd_log.push_back(rd_addr);
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
    if (wr_strobe && rd_strobe) both_cycles++;
  end

  int n_checks = 0, n_fail = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$], exp_dat[$], got_dat[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_ptr = 8'h00;

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; qwait();
    scl_c = 1'b1; qwait();
    sda_c = 1'b0; qwait();
    scl_c = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    scl_c = 1'b0; sda_c = 1'b0; qwait();
    scl_c = 1'b1; qwait();
    sda_c = 1'b1; qwait(); qwait();
  endtask

  task automatic put_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_c = b[i]; qwait();
      scl_c = 1'b1; qwait();
      if (glitch && i == 4) begin
        scl_glitch = 1'b1;
        repeat (2) @(negedge clk);
        scl_glitch = 1'b0;
      end
      qwait();
      scl_c = 1'b0; qwait();
    end
    sda_c = 1'b1; qwait();
    scl_c = 1'b1; qwait();
    ack = ~sda_di; qwait();
    scl_c = 1'b0; qwait();
  endtask

  task automatic get_byte(input bit ack_it, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_c = 1'b1; qwait();
      scl_c = 1'b1; qwait();
      b[i] = sda_di; qwait();
      scl_c = 1'b0; qwait();
    end
    sda_c = ~ack_it; qwait();
    scl_c = 1'b1; qwait(); qwait();
    scl_c = 1'b0; qwait();
  endtask

  // Write transaction; the model records expected strobes and memory contents.
  task automatic do_write(input logic [7:0] ptr, input logic [7:0] data [$],
                          input bit glitch, output int acks);
    bit a;
    acks = 0;
    i2c_start();
    put_byte(8'h84, 1'b0, a); acks += int'(a);
    put_byte(ptr, glitch, a); acks += int'(a);
    ref_ptr = ptr;
    foreach (data[k]) begin
      put_byte(data[k], glitch, a); acks += int'(a);
      exp_wr.push_back({ref_ptr, data[k]});
      ref_mem[ref_ptr] = data[k];
      ref_ptr++;
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic [7:0] ptr, input bit set_ptr, input int n, output int acks);
    bit a;
    logic [7:0] b;
    acks = 0;
    i2c_start();
    if (set_ptr) begin
      put_byte(8'h84, 1'b0, a); acks += int'(a);
      put_byte(ptr, 1'b0, a); acks += int'(a);
      ref_ptr = ptr;
      i2c_start();
    end
    put_byte(8'h85, 1'b0, a); acks += int'(a);
    for (int k = 0; k < n; k++) begin
      get_byte(k != n - 1, b);
      got_dat.push_back(b);
      exp_rd.push_back(ref_ptr);
      exp_dat.push_back(ref_mem[ref_ptr]);
      ref_ptr++;
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if ({wr_strobe, rd_strobe} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%b exp=00", {wr_strobe, rd_strobe}); end
    n_checks++; if ({wr_addr, wr_data, rd_addr} !== 24'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=000000", {wr_addr, wr_data, rd_addr}); end
    reset = 1'b0;
    qwait();
  endtask

  task automatic test_write();
    logic [7:0] d[$];
    int acks, wb, bb;
    wb = wr_log.size(); bb = busy_cycles;
    exp_wr.delete();
    d.push_back(8'hAA); d.push_back(8'hBB);
    do_write(8'h10, d, 1'b0, acks);
    n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL write_acks got=%0d exp=4", acks); end
    n_checks++; if (busy_cycles == bb) begin n_fail++; $display("FAIL write_busy_seen got=0 exp=1"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    n_checks++; if (wr_log.size() - wb != exp_wr.size()) begin n_fail++; $display("FAIL write_count got=%0d exp=%0d", wr_log.size() - wb, exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && wb + k < wr_log.size(); k++) begin
      n_checks++; if (wr_log[wb + k] !== exp_wr[k]) begin n_fail++; $display("FAIL write_strobe%0d got=%h exp=%h", k, wr_log[wb + k], exp_wr[k]); end
    end
  endtask

  task automatic test_read_sr();
    logic [7:0] d[$];
    int acks, rb, wb;
    exp_wr.delete();
    d.push_back(8'($urandom_range(0, 255))); d.push_back(8'($urandom_range(0, 255)));
    do_write(8'h20, d, 1'b0, acks);
    rb = rd_log.size(); wb = wr_log.size();
    exp_rd.delete(); exp_dat.delete(); got_dat.delete();
    do_read(8'h20, 1'b1, 2, acks);
    n_checks++; if (acks !== 3) begin n_fail++; $display("FAIL read_acks got=%0d exp=3", acks); end
    n_checks++; if (wr_log.size() != wb) begin n_fail++; $display("FAIL read_no_write got=%0d exp=0", wr_log.size() - wb); end
    n_checks++; if (rd_log.size() - rb != exp_rd.size()) begin n_fail++; $display("FAIL read_count got=%0d exp=%0d", rd_log.size() - rb, exp_rd.size()); end
    for (int k = 0; k < exp_rd.size() && rb + k < rd_log.size(); k++) begin
      n_checks++; if (rd_log[rb + k] !== exp_rd[k]) begin n_fail++; $display("FAIL read_addr%0d got=%h exp=%h", k, rd_log[rb + k], exp_rd[k]); end
      n_checks++; if (got_dat[k] !== exp_dat[k]) begin n_fail++; $display("FAIL read_data%0d got=%h exp=%h", k, got_dat[k], exp_dat[k]); end
    end
  endtask

  task automatic test_mismatch();
    bit a0, a1, a2;
    logic [7:0] d[$];
    int acks, wb, rb, ob, bb;
    wb = wr_log.size(); rb = rd_log.size(); ob = oe_cycles; bb = busy_cycles;
    i2c_start();
    put_byte(8'h90, 1'b0, a0);
    put_byte(8'h11, 1'b0, a1);
    put_byte(8'h22, 1'b0, a2);
    i2c_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL mismatch_acks got=%b exp=000", {a0, a1, a2}); end
    n_checks++; if (oe_cycles != ob) begin n_fail++; $display("FAIL mismatch_sda_oe got=%0d exp=0", oe_cycles - ob); end
    n_checks++; if (busy_cycles != bb) begin n_fail++; $display("FAIL mismatch_busy got=%0d exp=0", busy_cycles - bb); end
    n_checks++; if (wr_log.size() + rd_log.size() != wb + rb) begin n_fail++; $display("FAIL mismatch_strobes got=%0d exp=0", wr_log.size() + rd_log.size() - wb - rb); end
    exp_wr.delete();
    d.push_back(8'h5A);
    do_write(8'h30, d, 1'b0, acks);
    n_checks++; if (acks !== 3) begin n_fail++; $display("FAIL mismatch_next_acks got=%0d exp=3", acks); end
    n_checks++; if (wr_log.size() - wb != 1) begin n_fail++; $display("FAIL mismatch_next_count got=%0d exp=1", wr_log.size() - wb); end
    else begin
      n_checks++; if (wr_log[wb] !== exp_wr[0]) begin n_fail++; $display("FAIL mismatch_next_strobe got=%h exp=%h", wr_log[wb], exp_wr[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d[$];
    int acks, wb;
    wb = wr_log.size();
    exp_wr.delete();
    d.push_back(8'($urandom_range(0, 255))); d.push_back(8'($urandom_range(0, 255)));
    do_write(8'hFF, d, 1'b0, acks);
    n_checks++; if (wr_log.size() - wb != exp_wr.size()) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", wr_log.size() - wb, exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && wb + k < wr_log.size(); k++) begin
      n_checks++; if (wr_log[wb + k] !== exp_wr[k]) begin n_fail++; $display("FAIL wrap_strobe%0d got=%h exp=%h", k, wr_log[wb + k], exp_wr[k]); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d[$];
    int acks, wb;
    wb = wr_log.size();
    exp_wr.delete();
    d.push_back(8'($urandom_range(0, 255))); d.push_back(8'($urandom_range(0, 255)));
    do_write(8'($urandom_range(0, 255)), d, 1'b1, acks);
    n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL glitch_acks got=%0d exp=4", acks); end
    n_checks++; if (wr_log.size() - wb != exp_wr.size()) begin n_fail++; $display("FAIL glitch_count got=%0d exp=%0d", wr_log.size() - wb, exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && wb + k < wr_log.size(); k++) begin
      n_checks++; if (wr_log[wb + k] !== exp_wr[k]) begin n_fail++; $display("FAIL glitch_strobe%0d got=%h exp=%h", k, wr_log[wb + k], exp_wr[k]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    logic [7:0] ptr;
    int acks, wb, rb, n;
    for (int it = 0; it < 4; it++) begin
      ptr = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 3));
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(8'($urandom_range(0, 255)));
      wb = wr_log.size();
      exp_wr.delete();
      do_write(ptr, d, 1'b0, acks);
      n_checks++; if (wr_log.size() - wb != exp_wr.size()) begin n_fail++; $display("FAIL rand%0d_wcount got=%0d exp=%0d", it, wr_log.size() - wb, exp_wr.size()); end
      for (int k = 0; k < exp_wr.size() && wb + k < wr_log.size(); k++) begin
        n_checks++; if (wr_log[wb + k] !== exp_wr[k]) begin n_fail++; $display("FAIL rand%0d_wstrobe%0d got=%h exp=%h", it, k, wr_log[wb + k], exp_wr[k]); end
      end
      rb = rd_log.size();
      exp_rd.delete(); exp_dat.delete(); got_dat.delete();
      do_read(ptr, 1'b1, n, acks);
      n_checks++; if (rd_log.size() - rb != exp_rd.size()) begin n_fail++; $display("FAIL rand%0d_rcount got=%0d exp=%0d", it, rd_log.size() - rb, exp_rd.size()); end
      for (int k = 0; k < exp_rd.size() && rb + k < rd_log.size(); k++) begin
        n_checks++; if (rd_log[rb + k] !== exp_rd[k]) begin n_fail++; $display("FAIL rand%0d_raddr%0d got=%h exp=%h", it, k, rd_log[rb + k], exp_rd[k]); end
        n_checks++; if (got_dat[k] !== exp_dat[k]) begin n_fail++; $display("FAIL rand%0d_rdata%0d got=%h exp=%h", it, k, got_dat[k], exp_dat[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    bit a;
    int acks, rb;
    exp_wr.delete();
    d.push_back(8'h00);
    do_write(8'h40, d, 1'b0, acks);
    i2c_start();
    put_byte(8'h84, 1'b0, a);
    put_byte(8'h40, 1'b0, a);
    i2c_start();
    put_byte(8'h85, 1'b0, a);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_driving got=%b exp=1", sda_oe); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if ({wr_addr, wr_data, rd_addr} !== 24'h0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=000000", {wr_addr, wr_data, rd_addr}); end
    scl_c = 1'b1; sda_c = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ref_ptr = 8'h00;
    qwait();
    rb = rd_log.size();
    exp_rd.delete(); exp_dat.delete(); got_dat.delete();
    do_read(8'h00, 1'b0, 1, acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL rstmid_acks got=%0d exp=1", acks); end
    n_checks++; if (rd_log.size() - rb != 1) begin n_fail++; $display("FAIL rstmid_rcount got=%0d exp=1", rd_log.size() - rb); end
    else begin
      n_checks++; if (rd_log[rb] !== exp_rd[0]) begin n_fail++; $display("FAIL rstmid_raddr got=%h exp=%h", rd_log[rb], exp_rd[0]); end
      n_checks++; if (got_dat[0] !== exp_dat[0]) begin n_fail++; $display("FAIL rstmid_rdata got=%h exp=%h", got_dat[0], exp_dat[0]); end
    end
  endtask

  task automatic test_strobe_exclusive();
    n_checks++; if (both_cycles != 0) begin n_fail++; $display("FAIL strobe_exclusive got=%0d exp=0", both_cycles); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read_sr();
    test_mismatch();
    test_wrap();
    test_glitch();
    test_random();
    test_reset_mid();
    test_strobe_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
